// File: rtl/d_cache_wb.sv
// d_cache_wb: direct-mapped, write-back, write-allocate data cache.
// One word per line; each line keeps valid, dirty and tag state.
// A miss on a dirty victim writes the victim back before refilling.
// Hit and miss statistics counters saturate instead of wrapping.

module d_cache_wb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cache_en_i,
  input  logic              write_read_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  // Per-line bookkeeping; valid and dirty are cleared by reset, tag and
  // data are plain storage that is only meaningful while valid is set.
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  // Marks the cycle in which a hit response is presented.
  logic hit_rdy_q;

  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  miss_cnt_q;

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               line_hit;
  logic               victim_dirty;
  logic               req_take;
  logic               hit_take;
  logic               miss_take;
  logic               wb_done;
  logic               refill_done;
  logic               resp_write;

  assign req_index = addr_i[INDEX_W-1:0];
  assign req_tag   = addr_i[ADDR_W-1:INDEX_W];

  assign line_hit     = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign victim_dirty = valid_q[req_index] && dirty_q[req_index];

  // A request is accepted only in IDLE and never in the cycle a hit
  // response is being presented, so back-to-back hits take two cycles.
  assign req_take    = (state_q == IDLE) && cache_en_i && !hit_rdy_q;
  assign hit_take    = req_take && line_hit;
  assign miss_take   = req_take && !line_hit;
  assign wb_done     = (state_q == WB) && mem_ack_i;
  assign refill_done = (state_q == REFILL) && mem_ack_i;
  assign resp_write  = (state_q == RESP) && write_read_i;

  // State register; reset abandons any memory transaction immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: misses go through WB only when the victim is dirty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (miss_take) begin
          state_d = victim_dirty ? WB : REFILL;
        end
      end
      WB: begin
        if (mem_ack_i) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_ack_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: memory port is driven only in WB/REFILL, so it drops
  // as soon as reset forces the state back to IDLE.
  always_comb begin
    ready_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        ready_o = hit_rdy_q;
      end
      WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_mem[req_index], req_index};
        mem_wdata_o = data_mem[req_index];
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b0;
        mem_addr_o = addr_i;
      end
      RESP: begin
        ready_o = 1'b1;
      end
      default: begin
        ready_o = 1'b0;
      end
    endcase
  end

  // Line status bits and the hit-response flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      dirty_q   <= '0;
      hit_rdy_q <= 1'b0;
    end else begin
      hit_rdy_q <= hit_take;
      if (hit_take && write_read_i) begin
        dirty_q[req_index] <= 1'b1;
      end
      if (wb_done) begin
        dirty_q[req_index] <= 1'b0;
      end
      if (refill_done) begin
        valid_q[req_index] <= 1'b1;
        dirty_q[req_index] <= 1'b0;
      end
      if (resp_write) begin
        dirty_q[req_index] <= 1'b1;
      end
    end
  end

  // Tag and data storage; written on write hits, refills and write responses.
  always_ff @(posedge clk_i) begin
    if (hit_take && write_read_i) begin
      data_mem[req_index] <= data_i;
    end
    if (refill_done) begin
      data_mem[req_index] <= mem_rdata_i;
      tag_mem[req_index]  <= req_tag;
    end
    if (resp_write) begin
      data_mem[req_index] <= data_i;
    end
  end

  // Read data register; holds its value between read responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (hit_take && !write_read_i) begin
      data_q <= data_mem[req_index];
    end else if (refill_done && !write_read_i) begin
      data_q <= mem_rdata_i;
    end
  end

  // Saturating hit/miss statistics, counted when a request is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_take && (hit_cnt_q != {CNT_W{1'b1}})) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      if (miss_take && (miss_cnt_q != {CNT_W{1'b1}})) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign data_o     = data_q;
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_d_cache_wb.sv
// tb_d_cache_wb: directed and randomized checks of d_cache_wb against a
// word-addressed reference memory and a line-occupancy model.

module tb_d_cache_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_en;
  logic        write_read;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] data_o;
  logic        ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  logic        s_en;
  logic        s_we;
  logic [15:0] s_addr;
  logic [15:0] s_wdata;
  logic [15:0] s_data_o;
  logic        s_ready;
  logic        s_mem_req;
  logic        s_mem_we;
  logic [15:0] s_mem_addr;
  logic [15:0] s_mem_wdata;
  logic        s_mem_ack;
  logic [15:0] s_mem_rdata;
  logic [3:0]  s_hit_cnt;
  logic [3:0]  s_miss_cnt;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } mem_ev_t;

  mem_ev_t     ev_q[$];
  logic [15:0] backing [65536];
  logic [15:0] ref_mem [65536];
  int          ack_lat;
  int          wait_cnt;
  int          req_cycles;
  int          checks;
  int          failures;

  d_cache_wb dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cache_en_i   (cache_en),
    .write_read_i (write_read),
    .addr_i       (addr),
    .data_i       (wdata),
    .data_o       (data_o),
    .ready_o      (ready),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata),
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt)
  );

  d_cache_wb #(.CNT_W(4)) dut_sat (
    .clk_i        (clk),
    .rst_i        (rst),
    .cache_en_i   (s_en),
    .write_read_i (s_we),
    .addr_i       (s_addr),
    .data_i       (s_wdata),
    .data_o       (s_data_o),
    .ready_o      (s_ready),
    .mem_req_o    (s_mem_req),
    .mem_we_o     (s_mem_we),
    .mem_addr_o   (s_mem_addr),
    .mem_wdata_o  (s_mem_wdata),
    .mem_ack_i    (s_mem_ack),
    .mem_rdata_i  (s_mem_rdata),
    .hit_cnt_o    (s_hit_cnt),
    .miss_cnt_o   (s_miss_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Backing memory: acks after ack_lat extra cycles and logs each transfer.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst || !mem_req) begin
      wait_cnt = 0;
    end else begin
      req_cycles++;
      if (wait_cnt >= ack_lat) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_we) begin
          backing[mem_addr] = mem_wdata;
        end else begin
          mem_rdata = backing[mem_addr];
        end
        ev_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : backing[mem_addr]});
      end else begin
        wait_cnt++;
      end
    end
  end

  function automatic logic [15:0] pattern(input int i);
    return 16'((i * 7) ^ 16'h5A3C);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [15:0] a,
                               input logic [15:0] d, output logic [15:0] rd,
                               output int lat);
    bit done;
    @(posedge clk);
    @(negedge clk);
    write_read = we;
    addr       = a;
    wdata      = d;
    cache_en   = 1'b1;
    lat        = 0;
    rd         = '0;
    done       = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready) begin
        rd   = data_o;
        done = 1'b1;
      end else if (lat >= 200) begin
        checkOutput("req_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    cache_en = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    int          lat;
    int          rc;
    bit          mvalid [64];
    logic [9:0]  mtag   [64];
    int          mh;
    int          mm;
    int          nreq;

    checks     = 0;
    failures   = 0;
    req_cycles = 0;
    wait_cnt   = 0;
    ack_lat    = 2;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    rst        = 1'b1;
    cache_en   = 1'b0;
    write_read = 1'b0;
    addr       = '0;
    wdata      = '0;
    s_en       = 1'b0;
    s_we       = 1'b0;
    s_addr     = 16'h0003;
    s_wdata    = '0;
    s_mem_ack  = 1'b1;
    s_mem_rdata = 16'h7777;
    for (int i = 0; i < 65536; i++) begin
      backing[i] = pattern(i);
    end
    backing[5] = 16'hBEEF;

    #1;
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_data_o", 32'(data_o), 32'd0);
    checkOutput("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    checkOutput("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Cold read miss: a single refill of 0x0005.
    ev_q.delete();
    applyStimulus(1'b0, 16'h0005, 16'h0000, rd, lat);
    checkOutput("miss_ev_count", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() >= 1) begin
      checkOutput("miss_ev_we", 32'(ev_q[0].we), 32'd0);
      checkOutput("miss_ev_addr", 32'(ev_q[0].addr), 32'h0005);
    end
    checkOutput("miss_rdata", 32'(rd), 32'hBEEF);
    checkOutput("miss_cnt_1", 32'(miss_cnt), 32'd1);
    checkOutput("hit_cnt_0", 32'(hit_cnt), 32'd0);

    // Repeat read hits with one-cycle latency and no memory traffic.
    rc = req_cycles;
    applyStimulus(1'b0, 16'h0005, 16'h0000, rd, lat);
    checkOutput("hit_no_mem", 32'(req_cycles), 32'(rc));
    checkOutput("hit_latency", 32'(lat), 32'd1);
    checkOutput("hit_rdata", 32'(rd), 32'hBEEF);
    checkOutput("hit_cnt_1", 32'(hit_cnt), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("ready_pulse", 32'(ready), 32'd0);
    checkOutput("data_hold", 32'(data_o), 32'hBEEF);

    // Write hit dirties the line; conflicting read forces writeback first.
    applyStimulus(1'b1, 16'h0005, 16'h1234, rd, lat);
    checkOutput("whit_latency", 32'(lat), 32'd1);
    checkOutput("hit_cnt_2", 32'(hit_cnt), 32'd2);
    ev_q.delete();
    applyStimulus(1'b0, 16'h0045, 16'h0000, rd, lat);
    checkOutput("wb_ev_count", 32'(ev_q.size()), 32'd2);
    if (ev_q.size() >= 2) begin
      checkOutput("wb_ev_we", 32'(ev_q[0].we), 32'd1);
      checkOutput("wb_ev_addr", 32'(ev_q[0].addr), 32'h0005);
      checkOutput("wb_ev_data", 32'(ev_q[0].data), 32'h1234);
      checkOutput("refill_ev_we", 32'(ev_q[1].we), 32'd0);
      checkOutput("refill_ev_addr", 32'(ev_q[1].addr), 32'h0045);
    end
    checkOutput("conflict_rdata", 32'(rd), 32'(pattern(16'h0045)));
    checkOutput("miss_cnt_2", 32'(miss_cnt), 32'd2);

    // Reset in the middle of a refill drops the request at once.
    ack_lat = 1000;
    @(posedge clk);
    @(negedge clk);
    write_read = 1'b0;
    addr       = 16'h0100;
    cache_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("refill_pending", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
    checkOutput("abort_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("abort_miss_cnt", 32'(miss_cnt), 32'd0);
    checkOutput("abort_data_o", 32'(data_o), 32'd0);
    cache_en = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    ack_lat = 2;
    ev_q.delete();
    applyStimulus(1'b0, 16'h0005, 16'h0000, rd, lat);
    checkOutput("post_rst_ev_count", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() >= 1) begin
      checkOutput("post_rst_ev_addr", 32'(ev_q[0].addr), 32'h0005);
    end
    checkOutput("post_rst_rdata", 32'(rd), 32'h1234);
    checkOutput("post_rst_miss", 32'(miss_cnt), 32'd1);

    // Randomized traffic over a few tags and indices to mix hits and conflicts.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = backing[i];
    end
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = '0;
    end
    mh   = 0;
    mm   = 0;
    nreq = 400;
    for (int n = 0; n < nreq; n++) begin
      logic [9:0]  tg;
      logic [5:0]  ix;
      logic [15:0] a;
      logic [15:0] d;
      logic        we;
      bit          exp_hit;
      tg      = 10'($urandom_range(0, 3));
      ix      = 6'($urandom_range(0, 7));
      a       = {tg, ix};
      we      = 1'($urandom_range(0, 1));
      d       = 16'($urandom);
      ack_lat = int'($urandom_range(0, 3));
      exp_hit = mvalid[ix] && (mtag[ix] == tg);
      applyStimulus(we, a, d, rd, lat);
      if (we) begin
        ref_mem[a] = d;
      end else begin
        checkOutput("rand_rdata", 32'(rd), 32'(ref_mem[a]));
      end
      if (exp_hit) begin
        mh++;
        checkOutput("rand_hit_latency", 32'(lat), 32'd1);
      end else begin
        mm++;
        mvalid[ix] = 1'b1;
        mtag[ix]   = tg;
      end
    end
    checkOutput("rand_hit_cnt", 32'(hit_cnt), 32'(mh));
    checkOutput("rand_miss_cnt", 32'(miss_cnt), 32'(mm));
    checkOutput("rand_total", 32'(hit_cnt) + 32'(miss_cnt), 32'(nreq));

    // Narrow-counter instance: one miss then 20 hits must pin hit_cnt at 0xF.
    for (int k = 0; k < 21; k++) begin
      int w;
      @(posedge clk);
      @(negedge clk);
      s_en = 1'b1;
      w    = 0;
      while (!s_ready && w < 50) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (!s_ready) begin
        checkOutput("sat_timeout", 32'd0, 32'd1);
      end
      s_en = 1'b0;
    end
    checkOutput("sat_hit_cnt", 32'(s_hit_cnt), 32'hF);
    checkOutput("sat_miss_cnt", 32'(s_miss_cnt), 32'd1);
    checkOutput("sat_rdata", 32'(s_data_o), 32'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/d_cache_wb.md
D_CACHE_WB -- requirements
Module: d_cache_wb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data word width.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning word address width.
REQ-003 SHALL have parameter INDEX_W, default 6, meaning log2 line count; tag width = ADDR_W-INDEX_W.
REQ-004 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk_i  in  1  clock, all state updates on rising edge.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 cache_en_i  in  1  request valid; held until ready_o.
REQ-009 write_read_i  in  1  1 = write, 0 = read.
REQ-010 addr_i  in  ADDR_W  word address; index = addr_i[INDEX_W-1:0], tag = upper bits.
REQ-011 data_i  in  DATA_W  write data.
REQ-012 data_o  out  DATA_W  read data, valid when ready_o=1 on a read.
REQ-013 ready_o  out  1  one-cycle pulse, request complete.
REQ-014 mem_req_o  out  1  backing-memory request, held until mem_ack_i.
REQ-015 mem_we_o  out  1  1 = writeback, 0 = refill.
REQ-016 mem_addr_o  out  ADDR_W  backing-memory word address.
REQ-017 mem_wdata_o  out  DATA_W  writeback data.
REQ-018 mem_ack_i  in  1  memory completes the current request this cycle.
REQ-019 mem_rdata_i  in  DATA_W  refill data, valid with mem_ack_i.
REQ-020 hit_cnt_o / miss_cnt_o  out  CNT_W each  hit and miss counts.

Function
REQ-021 SHALL be direct-mapped, 2^INDEX_W lines, one word per line, with a valid bit, dirty bit and tag per line; write-back, write-allocate.
REQ-022 SHALL implement FSM states IDLE, WB, REFILL, RESP.
REQ-023 IDLE, cache_en_i=1, hit: read -> data_o = line data and ready_o=1 the cycle after sampling; write -> line data = data_i, dirty=1, ready_o=1 the cycle after; stay IDLE; hit_cnt +1.
REQ-024 IDLE, cache_en_i=1, miss: miss_cnt +1; if victim is valid and dirty -> WB, else -> REFILL.
REQ-025 WB: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag,index}, mem_wdata_o=victim data; on mem_ack_i clear dirty -> REFILL.
REQ-026 REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o=addr_i; on mem_ack_i install mem_rdata_i, set the tag, valid=1, dirty=0 -> RESP.
REQ-027 RESP: read -> data_o = installed word; write -> word = data_i, dirty=1; ready_o=1 for one cycle -> IDLE.
REQ-028 mem_req_o SHALL be 0 in IDLE and RESP; memory SHALL wait indefinitely for mem_ack_i; mem_ack_i outside WB/REFILL SHALL be ignored.
REQ-029 A new request SHALL NOT be sampled in the cycle ready_o=1; back-to-back hits complete one every two cycles.
REQ-030 data_o SHALL hold its last value when ready_o=0.
REQ-031 Counters SHALL saturate at all-ones and never wrap.
REQ-032 Changing addr_i, data_i or write_read_i while a miss is outstanding is illegal; the behaviour is undefined.

Reset
REQ-033 rst_i=1 SHALL immediately clear all valid and dirty bits, force IDLE, and drive ready_o, mem_req_o, mem_we_o, data_o, mem_addr_o, mem_wdata_o and both counters to 0.
REQ-034 Reset during WB or REFILL SHALL abandon the transaction; mem_req_o falls without waiting for the next clock edge; no line is updated.

Verification
REQ-035 After reset, read 0x0005 with mem_rdata_i=0xBEEF and 3-cycle ack -> one REFILL with mem_addr_o=0x0005, then ready_o with data_o=0xBEEF, miss_cnt=1.
REQ-036 Repeat read 0x0005 -> no mem_req_o, ready_o one cycle after the request, data_o=0xBEEF, hit_cnt=1.
REQ-037 Write 0x0005=0x1234 (hit), then read 0x0045 -> WB with mem_addr_o=0x0005 and mem_wdata_o=0x1234, then REFILL with mem_addr_o=0x0045.
REQ-038 Assert rst_i mid-REFILL -> mem_req_o=0 at once; the following read of 0x0005 misses (valid cleared).
REQ-039 Random read/write sequence against a reference memory model of 2^ADDR_W words -> every read data_o matches the model; hit_cnt+miss_cnt equals the request count.
REQ-040 Preload the counters near all-ones (CNT_W=4, 20 hits) -> hit_cnt saturates at 0xF.
